// File: rtl/sram_1rw_req_ctrl.sv
// sram_1rw_req_ctrl: registered 1RW macro request stage with credit-gated response FIFO
module sram_1rw_req_ctrl #(
    parameter int DATA_WIDTH = 2,
    parameter int ADDR_WIDTH = 4,
    parameter int RSP_DEPTH  = 4
) (
    input  logic                  clk0,
    input  logic                  rst0_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  csb0,
    output logic                  web0,
    output logic [ADDR_WIDTH-1:0] addr0,
    output logic [DATA_WIDTH-1:0] din0,
    input  logic [DATA_WIDTH-1:0] dout0
);
    localparam int PW = $clog2(RSP_DEPTH);
    logic                  rd_i;
    logic                  rd_m;
    logic [PW:0]           wr_ptr;
    logic [PW:0]           rd_ptr;
    logic [PW:0]           fifo_count;
    logic [PW+1:0]         credits;
    logic [DATA_WIDTH-1:0] mem [RSP_DEPTH];
    logic                  accept;
    logic                  push;
    logic                  pop;
    assign fifo_count = wr_ptr - rd_ptr;
    assign credits    = (PW+2)'(RSP_DEPTH) - {1'b0, fifo_count} - (PW+2)'(rd_i) - (PW+2)'(rd_m);
    assign req_ready  = credits != '0;
    assign accept     = req_valid && req_ready;
    assign push       = rd_m;
    assign rsp_valid  = wr_ptr != rd_ptr;
    assign pop        = rsp_valid && rsp_ready;
    assign rsp_rdata  = mem[rd_ptr[PW-1:0]];
    always_ff @(posedge clk0 or negedge rst0_n) begin
        if (!rst0_n) begin
            csb0   <= 1'b1;
            web0   <= 1'b1;
            addr0  <= '0;
            din0   <= '0;
            rd_i   <= 1'b0;
            rd_m   <= 1'b0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            csb0   <= !accept;
            web0   <= !(accept && req_we);
            addr0  <= accept ? req_addr : addr0;
            din0   <= accept ? req_wdata : din0;
            rd_i   <= accept && !req_we;
            rd_m   <= rd_i;
            wr_ptr <= push ? wr_ptr + (PW+1)'(1) : wr_ptr;
            rd_ptr <= pop ? rd_ptr + (PW+1)'(1) : rd_ptr;
        end
    end
    always_ff @(posedge clk0 or negedge rst0_n) begin
        if (!rst0_n) begin
            for (int i = 0; i < RSP_DEPTH; i++) mem[i] <= '0;
        end else if (push) begin
            mem[wr_ptr[PW-1:0]] <= dout0;
        end
    end
endmodule

// File: tb/tb_sram_1rw_req_ctrl.sv
// tb_sram_1rw_req_ctrl: randomized scoreboard bench with a behavioural macro and memory model
module tb_sram_1rw_req_ctrl;
    localparam int DW = 2;
    localparam int AW = 4;
    localparam int RSP_DEPTH = 4;
    typedef struct {
        logic [DW-1:0] d;
        int            acc;
    } exp_t;
    logic          clk0 = 1'b0;
    logic          rst0_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_rdata;
    logic          csb0;
    logic          web0;
    logic [AW-1:0] addr0;
    logic [DW-1:0] din0;
    logic [DW-1:0] dout0 = '0;
    logic [DW-1:0] sram [1<<AW];
    logic [DW-1:0] ref_mem [1<<AW];
    logic          m_csb = 1'b1;
    logic          m_web = 1'b1;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_din = '0;
    exp_t          q[$];
    int            compared = 0;
    int            mismatched = 0;
    int            cyc = 0;
    logic          pend = 1'b0;
    logic          pend_we = 1'b0;
    logic [AW-1:0] pend_a = '0;
    logic [DW-1:0] pend_d = '0;

    sram_1rw_req_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RSP_DEPTH(RSP_DEPTH)) dut (
        .clk0(clk0), .rst0_n(rst0_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .csb0(csb0), .web0(web0), .addr0(addr0), .din0(din0), .dout0(dout0)
    );

    always #5 clk0 = ~clk0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    task automatic drive(input logic v, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic rr);
        @(posedge clk0);
        #1;
        req_valid = v;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        rsp_ready = rr;
    endtask

    // behavioural 1RW macro: latch pins at posedge, write or read at the following negedge
    always @(posedge clk0) begin
        cyc++;
        m_csb  <= csb0;
        m_web  <= web0;
        m_addr <= addr0;
        m_din  <= din0;
        if (rst0_n && dut.rd_m && dut.fifo_count == 3'(RSP_DEPTH)) begin
            mismatched++;
            $display("FAIL fifo_overflow: push into full FIFO at cycle %0d", cyc);
        end
    end

    always @(negedge clk0) begin
        if (!m_csb && !m_web) sram[m_addr] = m_din;
        dout0 = (!m_csb && m_web) ? sram[m_addr] : DW'($urandom);
    end

    always @(negedge clk0) begin
        logic ev;
        logic rdy;
        if (!rst0_n) begin
            chk("rst_csb0", csb0, 1);
            chk("rst_web0", web0, 1);
            chk("rst_addr0", addr0, 0);
            chk("rst_din0", din0, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_rsp_rdata", rsp_rdata, 0);
            chk("rst_req_ready", req_ready, 1);
            q.delete();
            pend = 1'b0;
        end else begin
            ev  = q.size() > 0 && cyc >= q[0].acc + 2;
            rdy = q.size() < RSP_DEPTH;
            chk("req_ready", req_ready, rdy);
            chk("rsp_valid", rsp_valid, ev);
            if (ev) chk("rsp_rdata", rsp_rdata, q[0].d);
            chk("csb0", csb0, !pend);
            if (pend) begin
                chk("web0", web0, !pend_we);
                chk("addr0", addr0, pend_a);
                chk("din0", din0, pend_d);
            end
            if (ev && rsp_ready) void'(q.pop_front());
            pend = req_valid && rdy;
            if (pend) begin
                pend_we = req_we;
                pend_a  = req_addr;
                pend_d  = req_wdata;
                if (req_we) ref_mem[req_addr] = req_wdata;
                else q.push_back('{ref_mem[req_addr], cyc + 1});
            end
        end
    end

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            sram[i]    = '0;
            ref_mem[i] = '0;
        end
        repeat (3) @(posedge clk0);
        #1 rst0_n = 1'b1;
        repeat (3) drive(0, 0, 0, 0, 1);
        for (int a = 0; a < (1 << AW); a++) drive(1, 1, AW'(a), DW'(a), 1);
        drive(1, 1, 5, 2'b10, 1);
        repeat (2) drive(0, 0, 0, 0, 1);
        drive(1, 0, 5, 0, 1);
        repeat (3) drive(0, 0, 0, 0, 1);
        drive(1, 1, 3, 2'b01, 1);
        drive(1, 0, 3, 0, 1);
        repeat (3) drive(0, 0, 0, 0, 1);
        for (int i = 0; i < 6; i++) drive(1, 0, AW'(i), 0, 0);
        repeat (3) drive(0, 0, 0, 0, 0);
        repeat (6) drive(0, 0, 0, 0, 1);
        for (int i = 0; i < 20; i++) drive(1, 0, AW'(i), 0, 1);
        repeat (4) drive(0, 0, 0, 0, 1);
        for (int i = 0; i < 400; i++)
            drive(1'($urandom), 1'($urandom), AW'($urandom), DW'($urandom), $urandom_range(0, 3) != 0);
        repeat (8) drive(0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) drive(1, 0, AW'(i + 8), 0, 0);
        @(posedge clk0);
        #3;
        chk("pre_rst_csb0", csb0, 0);
        chk("pre_rst_rsp_valid", rsp_valid, 1);
        rst0_n = 1'b0;
        #1;
        chk("async_rst_csb0", csb0, 1);
        chk("async_rst_rsp_valid", rsp_valid, 0);
        req_valid = 1'b0;
        repeat (2) @(posedge clk0);
        #1 rst0_n = 1'b1;
        repeat (6) drive(0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) drive(1, 0, AW'(i), 0, 1);
        repeat (5) drive(0, 0, 0, 0, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
